alu_vector_driver: RTL and testbench

//  Sequential stimulus/check engine on the driving side of the 32-bit ALU port (A, B, ALUctr -> Result, Zero, Overflow).

---
 rtl/alu_vec_pkg.sv | 62 ++++++
 rtl/alu_vec_rom.sv | 19 +
 rtl/alu_vector_driver.sv | 157 +++++++++++++++
 tb/tb_alu_vector_driver.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_vec_pkg.sv
// Purpose : opcode constants, vector record type, FSM state type and the fixed ALU self-test table.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
// Contents: OP_ADDU..OP_SLT opcodes, vec_t {A, B, ctr, exp_res, exp_zero, exp_ovf}, VEC[VEC_COUNT],
//           state_t for the driver FSM, ovf_checked() helper.
package alu_vec_pkg;

    localparam int VEC_COUNT = 16;
    localparam int VEC_IDX_W = $clog2(VEC_COUNT);

    localparam logic [2:0] OP_ADDU = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_SUBU = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef struct packed {
        logic [31:0] A;
        logic [31:0] B;
        logic [2:0]  ctr;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ovf;
    } vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Operand values are decimal where written as 32'd, hex otherwise.
    // Opcode 3'b011 is unused by the ALU and never appears here.
    localparam vec_t VEC [VEC_COUNT] = '{
        '{32'd16,         32'd18,         OP_ADDU, 32'd34,         1'b0, 1'b0},
        '{32'hFFFF_FFF1,  32'h0000_000F,  OP_ADDU, 32'h0000_0000,  1'b1, 1'b0},
        '{32'h7FFF_FFF1,  32'h0000_000F,  OP_ADD,  32'h8000_0000,  1'b0, 1'b1},
        '{32'h8000_0001,  32'h8000_0001,  OP_ADD,  32'h0000_0002,  1'b0, 1'b1},
        '{32'h1111_1111,  32'h8888_8888,  OP_OR,   32'h9999_9999,  1'b0, 1'b0},
        '{32'd16,         32'd16,         OP_SUBU, 32'h0000_0000,  1'b1, 1'b0},
        '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  OP_SUB,  32'h8000_0000,  1'b0, 1'b1},
        '{32'h8000_0001,  32'h0000_0002,  OP_SUB,  32'h7FFF_FFFF,  1'b0, 1'b1},
        '{32'd16,         32'hFFFF_FFFF,  OP_SLTU, 32'h0000_0001,  1'b0, 1'b0},
        '{32'd16,         32'hFFFF_FFFF,  OP_SLT,  32'h0000_0000,  1'b1, 1'b0},
        '{32'h1234_5678,  32'h1111_1111,  OP_ADDU, 32'h2345_6789,  1'b0, 1'b0},
        '{32'h0000_0005,  32'h0000_0003,  OP_SUB,  32'h0000_0002,  1'b0, 1'b0},
        '{32'h0000_0000,  32'h0000_0000,  OP_OR,   32'h0000_0000,  1'b1, 1'b0},
        '{32'hFFFF_FFFF,  32'h0000_0001,  OP_SLT,  32'h0000_0001,  1'b0, 1'b0},
        '{32'h0000_0001,  32'h0000_0001,  OP_SLTU, 32'h0000_0000,  1'b1, 1'b0},
        '{32'hA5A5_A5A5,  32'h5A5A_5A5A,  OP_SUBU, 32'h4B4B_4B4B,  1'b0, 1'b0}
    };

    // Only the signed add/sub opcodes define Overflow; it is don't-care elsewhere.
    function automatic logic ovf_checked(input logic [2:0] ctr);
        return (ctr == OP_ADD) || (ctr == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_vec_rom.sv
// Purpose : combinational lookup of one self-test vector by index.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; output follows idx every cycle.
// Ports   : idx (8b vector index) -> vec (vec_t); out-of-range indices return all zeros.
module alu_vec_rom
    import alu_vec_pkg::*;
(
    input  logic [7:0] idx,
    output vec_t       vec
);

    always_comb begin
        vec = '0;
        if (32'(idx) < 32'(VEC_COUNT)) begin
            vec = VEC[idx[VEC_IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/alu_vector_driver.sv
// Purpose : BIST engine that drives the 32-bit ALU from a fixed vector table and checks its outputs.
// Latency : SETTLE_CYC+2 cycles per vector, NUM_VEC*(SETTLE_CYC+2) cycles from first DRIVE to DONE.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
// Ports   : clk, rst (sync, active-high), start -> A, B, ALUctr (registered ALU stimulus);
//           Result, Zero, Overflow (ALU response) -> busy, done, pass, fail_cnt.
// Option  : ALU_VEC_CAPTURE_EN adds fail_idx/fail_res/fail_flags holding the first mismatch of a run.
module alu_vector_driver
    import alu_vec_pkg::*;
#(
    parameter int N          = 32,
    parameter int NUM_VEC    = VEC_COUNT,
    parameter int SETTLE_CYC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [2:0]   ALUctr,
    input  logic [N-1:0] Result,
    input  logic         Zero,
    input  logic         Overflow,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [7:0]   fail_cnt
`ifdef ALU_VEC_CAPTURE_EN
    ,
    output logic [7:0]   fail_idx,
    output logic [N-1:0] fail_res,
    output logic [1:0]   fail_flags
`endif
);

    localparam logic [7:0] LAST_IDX      = 8'(NUM_VEC - 1);
    localparam int         SETTLE_LAST_I = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
    localparam logic [3:0] SETTLE_LAST   = 4'(SETTLE_LAST_I);

    state_t       state;
    logic [7:0]   idx;
    logic [3:0]   settle_cnt;
    vec_t         cur_vec;
    logic [N-1:0] exp_res_n;
    logic         mismatch;
    logic         first_fail;

    alu_vec_rom u_rom (
        .idx (idx),
        .vec (cur_vec)
    );

    assign exp_res_n = N'(cur_vec.exp_res);

    // idx is stable from DRIVE through CHECK, so the ROM output seen in CHECK
    // is the same vector that was registered onto A/B/ALUctr.
    always_comb begin
        mismatch = (Result != exp_res_n) || (Zero != cur_vec.exp_zero) ||
                   (ovf_checked(ALUctr) && (Overflow != cur_vec.exp_ovf));
    end

    // fail_cnt is cleared on start, so zero here means no mismatch yet this run.
    assign first_fail = mismatch && (fail_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            A          <= '0;
            B          <= '0;
            ALUctr     <= OP_ADDU;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_cnt   <= '0;
`ifdef ALU_VEC_CAPTURE_EN
            fail_idx   <= '0;
            fail_res   <= '0;
            fail_flags <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_DRIVE;
                        idx        <= '0;
                        fail_cnt   <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
`ifdef ALU_VEC_CAPTURE_EN
                        fail_idx   <= '0;
                        fail_res   <= '0;
                        fail_flags <= '0;
`endif
                    end
                end

                ST_DRIVE: begin
                    A          <= N'(cur_vec.A);
                    B          <= N'(cur_vec.B);
                    ALUctr     <= cur_vec.ctr;
                    settle_cnt <= '0;
                    if (SETTLE_CYC == 0) begin
                        state <= ST_CHECK;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                ST_CHECK: begin
                    if (mismatch && (fail_cnt != 8'hFF)) begin
                        fail_cnt <= fail_cnt + 8'd1;
                    end
`ifdef ALU_VEC_CAPTURE_EN
                    if (first_fail) begin
                        fail_idx   <= idx;
                        fail_res   <= Result;
                        fail_flags <= {Zero, Overflow};
                    end
`endif
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Include the verdict of the last vector, whose count update lands this same edge.
                        pass  <= (fail_cnt == 8'd0) && !mismatch;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= ST_DRIVE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifndef ALU_VEC_CAPTURE_EN
    // first_fail only feeds the capture registers.
    logic unused_first_fail;
    assign unused_first_fail = first_fail;
`endif

endmodule

// File: tb/tb_alu_vector_driver.sv
`timescale 1ns/1ps
module tb_alu_vector_driver;

    localparam int NV = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        v;
    } aluo_t;

    // Fault injection knobs applied to the behavioural ALU in front of the DUTs.
    int          fmode = 0;
    logic [31:0] fmask = '0;
    logic [7:0]  fset  = '0;

    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  c0, c1;
    aluo_t       o0, o1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0]  fc0, fc1;
`ifdef ALU_VEC_CAPTURE_EN
    logic [7:0]  fidx0, fidx1;
    logic [31:0] fres0, fres1;
    logic [1:0]  ffl0, ffl1;
`endif

    // Reference ALU: plain arithmetic, overflow = exact sum differs from the wrapped signed result.
    function automatic aluo_t alu_golden(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        aluo_t  o;
        longint sa, sb, exact;
        o  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            3'b000: o.res = a + b;
            3'b001: begin o.res = a + b; exact = sa + sb; o.v = (exact != longint'($signed(o.res))); end
            3'b010: o.res = a | b;
            3'b100: o.res = a - b;
            3'b101: begin o.res = a - b; exact = sa - sb; o.v = (exact != longint'($signed(o.res))); end
            3'b110: o.res = (a < b) ? 32'd1 : 32'd0;
            3'b111: o.res = (sa < sb) ? 32'd1 : 32'd0;
            default: o.res = '0;
        endcase
        o.z = (o.res == 32'd0);
        return o;
    endfunction

    function automatic aluo_t faulty(input aluo_t g, input logic [2:0] c, input int mode,
                                     input logic [31:0] mask, input logic [7:0] set);
        aluo_t f;
        f = g;
        case (mode)
            1: f.res[0] = 1'b0;
            2: if (c != 3'b001 && c != 3'b101) f.v = 1'b1;
            3: if (c == 3'b001) f.v = ~g.v;
            4: if (set[c]) begin f.res = g.res ^ mask; f.z = (f.res == 32'd0); end
            default: ;
        endcase
        return f;
    endfunction

    assign o0 = faulty(alu_golden(a0, b0, c0), c0, fmode, fmask, fset);
    assign o1 = faulty(alu_golden(a1, b1, c1), c1, fmode, fmask, fset);

    alu_vector_driver #(.N(32), .NUM_VEC(NV), .SETTLE_CYC(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .A(a0), .B(b0), .ALUctr(c0),
        .Result(o0.res), .Zero(o0.z), .Overflow(o0.v),
        .busy(busy0), .done(done0), .pass(pass0), .fail_cnt(fc0)
`ifdef ALU_VEC_CAPTURE_EN
        , .fail_idx(fidx0), .fail_res(fres0), .fail_flags(ffl0)
`endif
    );

    alu_vector_driver #(.N(32), .NUM_VEC(NV), .SETTLE_CYC(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .A(a1), .B(b1), .ALUctr(c1),
        .Result(o1.res), .Zero(o1.z), .Overflow(o1.v),
        .busy(busy1), .done(done1), .pass(pass1), .fail_cnt(fc1)
`ifdef ALU_VEC_CAPTURE_EN
        , .fail_idx(fidx1), .fail_res(fres1), .fail_flags(ffl1)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cur_sel = 0;

    logic        m_busy, m_done, m_pass;
    logic [7:0]  m_fc;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_c;
`ifdef ALU_VEC_CAPTURE_EN
    logic [7:0]  m_fidx;
    logic [31:0] m_fres;
    logic [1:0]  m_ffl;
`endif

    always_comb begin
        m_busy = (cur_sel == 1) ? busy1 : busy0;
        m_done = (cur_sel == 1) ? done1 : done0;
        m_pass = (cur_sel == 1) ? pass1 : pass0;
        m_fc   = (cur_sel == 1) ? fc1   : fc0;
        m_a    = (cur_sel == 1) ? a1    : a0;
        m_b    = (cur_sel == 1) ? b1    : b0;
        m_c    = (cur_sel == 1) ? c1    : c0;
`ifdef ALU_VEC_CAPTURE_EN
        m_fidx = (cur_sel == 1) ? fidx1 : fidx0;
        m_fres = (cur_sel == 1) ? fres1 : fres0;
        m_ffl  = (cur_sel == 1) ? ffl1  : ffl0;
`endif
    end

    // Vectors observed in the CHECK cycle of the latest run.
    logic [31:0] ra [NV];
    logic [31:0] rb [NV];
    logic [2:0]  rc [NV];
    int          rec_n;
    int          unstable;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) start1 = v;
        else start0 = v;
    endtask

    // Pulse start and follow the run at negedges. mid_start/rst_at are busy-cycle numbers (-1 = off).
    task automatic do_run(input int sel, input int mid_start, input int rst_at,
                          output int busy_n, output bit got_done);
        int          per;
        logic [31:0] pa, pb;
        logic [2:0]  pc;
        cur_sel  = sel;
        per      = (sel == 1) ? 2 : 3;
        busy_n   = 0;
        got_done = 1'b0;
        rec_n    = 0;
        unstable = 0;
        pa = '0; pb = '0; pc = '0;
        @(negedge clk); set_start(sel, 1'b1);
        @(negedge clk); set_start(sel, 1'b0);
        check("done_drop", 64'(m_done), 64'd0);
        check("busy_rise", 64'(m_busy), 64'd1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (m_done) begin
                got_done = 1'b1;
                break;
            end
            if (m_busy) begin
                busy_n++;
                if (busy_n % per == 0) begin
                    if (rec_n < NV) begin
                        ra[rec_n] = m_a; rb[rec_n] = m_b; rc[rec_n] = m_c;
                        rec_n++;
                    end
                    if (per == 3 && (m_a !== pa || m_b !== pb || m_c !== pc)) unstable++;
                end else if (per == 3 && busy_n % per == 2) begin
                    pa = m_a; pb = m_b; pc = m_c;
                end
            end
            if (busy_n == mid_start) set_start(sel, 1'b1);
            if (busy_n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                set_start(sel, 1'b0);
                break;
            end
            @(negedge clk);
            set_start(sel, 1'b0);
        end
    endtask

    // Expected outcome of the recorded run under the current fault, from the mismatch rule.
    task automatic predict(output int exp_fc, output int exp_first,
                           output logic [31:0] exp_fres, output logic [1:0] exp_ffl);
        aluo_t g, f;
        bit    mism;
        exp_fc = 0; exp_first = 0; exp_fres = '0; exp_ffl = '0;
        for (int k = 0; k < rec_n; k++) begin
            g = alu_golden(ra[k], rb[k], rc[k]);
            f = faulty(g, rc[k], fmode, fmask, fset);
            mism = (f.res != g.res) || (f.z != g.z) ||
                   ((rc[k] == 3'b001 || rc[k] == 3'b101) && (f.v != g.v));
            if (mism) begin
                if (exp_fc == 0) begin
                    exp_first = k; exp_fres = f.res; exp_ffl = {f.z, f.v};
                end
                exp_fc++;
            end
        end
        if (exp_fc > 255) exp_fc = 255;
    endtask

    task automatic check_run(input string tag, input int exp_busy);
        int          bn, efc, efirst;
        bit          gd;
        logic [31:0] efres;
        logic [1:0]  effl;
        do_run(cur_sel, -1, -1, bn, gd);
        check({tag, "_done"}, 64'(gd), 64'd1);
        check({tag, "_busy_cycles"}, 64'(bn), 64'(exp_busy));
        check({tag, "_recorded"}, 64'(rec_n), 64'(NV));
        predict(efc, efirst, efres, effl);
        check({tag, "_fail_cnt"}, 64'(m_fc), 64'(efc));
        check({tag, "_pass"}, 64'(m_pass), 64'(efc == 0));
`ifdef ALU_VEC_CAPTURE_EN
        check({tag, "_fail_idx"}, 64'(m_fidx), 64'(efirst));
        check({tag, "_fail_res"}, 64'(m_fres), 64'(efres));
        check({tag, "_fail_flags"}, 64'(m_ffl), 64'(effl));
`endif
    endtask

    logic [31:0] req_a [10] = '{32'd16, 32'hFFFFFFF1, 32'h7FFFFFF1, 32'h80000001, 32'h11111111,
                                32'd16, 32'h7FFFFFFF, 32'h80000001, 32'd16, 32'd16};
    logic [31:0] req_b [10] = '{32'd18, 32'h0000000F, 32'h0000000F, 32'h80000001, 32'h88888888,
                                32'd16, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [2:0]  req_c [10] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010,
                                3'b100, 3'b101, 3'b101, 3'b110, 3'b111};

    initial begin
        int bn, n011, n001;
        bit gd, found;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_A0", 64'(a0), 64'd0);
        check("rst_B0", 64'(b0), 64'd0);
        check("rst_ctr0", 64'(c0), 64'd0);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_done0", 64'(done0), 64'd0);
        check("rst_pass0", 64'(pass0), 64'd0);
        check("rst_fc0", 64'(fc0), 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
        check("rst_A1", 64'(a1), 64'd0);

        // Good run, settle 1: 16 vectors x 3 cycles
        cur_sel = 0; fmode = 0;
        check_run("good", 48);
        check("good_stable", 64'(unstable), 64'd0);
        check("good_hold_A", 64'(a0), 64'(ra[NV-1]));
        check("good_hold_ctr", 64'(c0), 64'(rc[NV-1]));
        n011 = 0; n001 = 0;
        for (int k = 0; k < rec_n; k++) begin
            if (rc[k] == 3'b011) n011++;
            if (rc[k] == 3'b001) n001++;
        end
        check("no_op011", 64'(n011), 64'd0);
        for (int r = 0; r < 10; r++) begin
            found = 1'b0;
            for (int k = 0; k < rec_n; k++)
                if (ra[k] == req_a[r] && rb[k] == req_b[r] && rc[k] == req_c[r]) found = 1'b1;
            check($sformatf("table_has_%0d", r), 64'(found), 64'd1);
        end

        // Result[0] stuck at 0
        fmode = 1;
        check_run("stuck0", 48);

        // Overflow forced high on non-signed opcodes: don't-care
        fmode = 2;
        check_run("ovf_dc", 48);
        check("ovf_dc_pass", 64'(pass0), 64'd1);

        // Overflow inverted on add only: one failure per add entry
        fmode = 3;
        check_run("ovf_add", 48);
        check("ovf_add_cnt", 64'(fc0), 64'(n001));

        // start mid-run is ignored
        fmode = 0;
        do_run(0, 10, -1, bn, gd);
        check("midstart_done", 64'(gd), 64'd1);
        check("midstart_cycles", 64'(bn), 64'd48);
        check("midstart_pass", 64'(pass0), 64'd1);

        // rst mid-run with failures accumulating
        fmode = 1;
        do_run(0, -1, 20, bn, gd);
        check("midrst_busy", 64'(busy0), 64'd0);
        check("midrst_done", 64'(done0), 64'd0);
        check("midrst_pass", 64'(pass0), 64'd0);
        check("midrst_fc", 64'(fc0), 64'd0);
        check("midrst_A", 64'(a0), 64'd0);
        check("midrst_ctr", 64'(c0), 64'd0);
        fmode = 0;
        check_run("after_rst", 48);

        // Zero settle: 16 vectors x 2 cycles, then rerun from DONE clears the count
        cur_sel = 1; fmode = 1;
        check_run("z_fault", 32);
        fmode = 0;
        check_run("z_clean", 32);
        check("z_clean_fc", 64'(fc1), 64'd0);

        // Randomized faults on random opcode subsets
        for (int it = 0; it < 6; it++) begin
            fmode   = 4;
            fmask   = $urandom;
            if (fmask == 32'd0) fmask = 32'd1;
            fset    = 8'($urandom_range(0, 255));
            cur_sel = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 4)) @(negedge clk);
            check_run($sformatf("rnd%0d", it), (cur_sel == 1) ? 32 : 48);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
